// File: rtl/conv_pkg.sv
// Shared state encoding and geometry helpers for the convolution layer sequencer.
package conv_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StMac,
        StDrain,
        StEmit,
        StDone
    } state_e;

    // Never returns less than 1, so every derived vector has at least one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    function automatic int unsigned out_size(input int unsigned image, input int unsigned kernel);
        return image - kernel + 1;
    endfunction

    function automatic int unsigned strip_count(input int unsigned outs, input int unsigned lanes);
        return (outs + lanes - 1) / lanes;
    endfunction

    function automatic int unsigned win_size(input int unsigned lanes, input int unsigned kernel);
        return lanes + kernel - 1;
    endfunction

endpackage

// File: rtl/conv_seq_counter.sv
// Wrap-around loop counter with synchronous clear and a terminal-count flag.
module conv_seq_counter #(
    parameter int unsigned Modulus = 2,
    parameter int unsigned Width   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [Width-1:0] value,
    output logic             last
);

    logic [Width-1:0] value_q;

    assign last  = (value_q == Width'(Modulus - 1));
    assign value = value_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            value_q <= '0;
        end else if (inc) begin
            value_q <= last ? '0 : value_q + Width'(1);
        end
    end

endmodule

// File: rtl/conv_layer_sequencer.sv
// Control engine for one convolution layer: row/strip/channel/kernel-row walk with strip handshake.
// Define CONV_SEQ_PERF_EN to add the perf_cycles / perf_stalls counters.
module conv_layer_sequencer
    import conv_pkg::*;
#(
    parameter int unsigned IMAGE_SIZE  = 8,
    parameter int unsigned KERNEL_SIZE = 3,
    parameter int unsigned ARRAY_SIZE  = 6,
    parameter int unsigned IN_CHANNELS = 1,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned WADDR_WIDTH = 6,
    parameter int unsigned ACC_LATENCY = 1
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           start,
    output logic                                           rom_en,
    output logic [ADDR_WIDTH-1:0]                          rom_addr,
    output logic                                           load_en,
    output logic                                           load_zero,
    output logic [clog2(ARRAY_SIZE + KERNEL_SIZE - 1)-1:0] load_idx,
    output logic [WADDR_WIDTH-1:0]                         weight_addr,
    output logic                                           mac_en,
    output logic                                           acc_clr,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [ARRAY_SIZE-1:0]                          out_mask,
    output logic [clog2(IMAGE_SIZE)-1:0]                   out_row,
    output logic [clog2(IMAGE_SIZE)-1:0]                   out_col,
    output logic                                           busy,
    output logic                                           done
`ifdef CONV_SEQ_PERF_EN
    ,
    output logic [31:0]                                    perf_cycles,
    output logic [31:0]                                    perf_stalls
`endif
);

    localparam int unsigned OUT_SIZE = out_size(IMAGE_SIZE, KERNEL_SIZE);
    localparam int unsigned STRIPS   = strip_count(OUT_SIZE, ARRAY_SIZE);
    localparam int unsigned WIN      = win_size(ARRAY_SIZE, KERNEL_SIZE);
    localparam int unsigned IDX_W    = clog2(WIN);
    localparam int unsigned KC_W     = clog2(KERNEL_SIZE);
    localparam int unsigned CH_W     = clog2(IN_CHANNELS);
    localparam int unsigned STRIP_W  = clog2(STRIPS);
    localparam int unsigned ROW_W    = clog2(OUT_SIZE);
    localparam int unsigned LAT_W    = clog2(ACC_LATENCY);
    localparam int unsigned POS_W    = clog2(IMAGE_SIZE);

    if (64'(IN_CHANNELS) * IMAGE_SIZE * IMAGE_SIZE > (64'd1 << ADDR_WIDTH)) begin : g_addr_chk
        $error("pixel address space does not fit ADDR_WIDTH");
    end
    if (64'(IN_CHANNELS) * KERNEL_SIZE * KERNEL_SIZE > (64'd1 << WADDR_WIDTH)) begin : g_waddr_chk
        $error("weight address space does not fit WADDR_WIDTH");
    end
    if (ACC_LATENCY < 1) begin : g_lat_chk
        $error("ACC_LATENCY must be at least 1");
    end

    state_e state_q, state_d;

    logic               cnt_clr;
    logic               idx_inc, kc_inc, kr_inc, ch_inc, strip_inc, row_inc;
    logic               idx_last, kc_last, kr_last, ch_last, strip_last, row_last;
    logic [IDX_W-1:0]   idx;
    logic [KC_W-1:0]    kc, kr;
    logic [CH_W-1:0]    ch;
    logic [STRIP_W-1:0] strip;
    logic [ROW_W-1:0]   row;
    logic [LAT_W-1:0]   lat_q;
    logic               lat_last;
    logic [31:0]        lane_base, col;
    logic               col_in;
    logic               load_en_q, load_zero_q;
    logic [IDX_W-1:0]   load_idx_q;

    conv_seq_counter #(.Modulus(WIN), .Width(IDX_W)) u_idx (
        .clk(clk), .rst(rst_n), .clear(cnt_clr), .inc(idx_inc), .value(idx), .last(idx_last)
    );
    conv_seq_counter #(.Modulus(KERNEL_SIZE), .Width(KC_W)) u_kc (
        .clk(clk), .rst(rst_n), .clear(cnt_clr), .inc(kc_inc), .value(kc), .last(kc_last)
    );
    conv_seq_counter #(.Modulus(KERNEL_SIZE), .Width(KC_W)) u_kr (
        .clk(clk), .rst(rst_n), .clear(cnt_clr), .inc(kr_inc), .value(kr), .last(kr_last)
    );
    conv_seq_counter #(.Modulus(IN_CHANNELS), .Width(CH_W)) u_ch (
        .clk(clk), .rst(rst_n), .clear(cnt_clr), .inc(ch_inc), .value(ch), .last(ch_last)
    );
    conv_seq_counter #(.Modulus(STRIPS), .Width(STRIP_W)) u_strip (
        .clk(clk), .rst(rst_n), .clear(cnt_clr), .inc(strip_inc), .value(strip), .last(strip_last)
    );
    conv_seq_counter #(.Modulus(OUT_SIZE), .Width(ROW_W)) u_row (
        .clk(clk), .rst(rst_n), .clear(cnt_clr), .inc(row_inc), .value(row), .last(row_last)
    );

    assign lane_base = 32'(strip) * ARRAY_SIZE;
    assign col       = lane_base + 32'(idx);
    assign col_in    = col < IMAGE_SIZE;
    assign lat_last  = (lat_q == LAT_W'(ACC_LATENCY - 1));

    always_comb begin
        state_d   = state_q;
        cnt_clr   = 1'b0;
        idx_inc   = 1'b0;
        kc_inc    = 1'b0;
        kr_inc    = 1'b0;
        ch_inc    = 1'b0;
        strip_inc = 1'b0;
        row_inc   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StLoad;
                    cnt_clr = 1'b1;
                end
            end
            StLoad: begin
                idx_inc = 1'b1;
                if (idx_last) state_d = StMac;
            end
            StMac: begin
                kc_inc = 1'b1;
                if (kc_last) begin
                    kr_inc  = 1'b1;
                    ch_inc  = kr_last;
                    state_d = (kr_last && ch_last) ? StDrain : StLoad;
                end
            end
            StDrain: begin
                if (lat_last) state_d = StEmit;
            end
            StEmit: begin
                if (out_ready) begin
                    strip_inc = 1'b1;
                    row_inc   = strip_last;
                    state_d   = (strip_last && row_last) ? StDone : StLoad;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= StIdle;
            lat_q       <= '0;
            load_en_q   <= 1'b0;
            load_zero_q <= 1'b0;
            load_idx_q  <= '0;
        end else begin
            state_q     <= state_d;
            lat_q       <= (state_q == StDrain && !lat_last) ? lat_q + LAT_W'(1) : '0;
            // Array loads trail the ROM request by one cycle to match ROM read latency.
            load_en_q   <= (state_q == StLoad);
            load_zero_q <= (state_q == StLoad) && !col_in;
            load_idx_q  <= (state_q == StLoad) ? idx : '0;
        end
    end

    assign rom_en      = (state_q == StLoad) && col_in;
    assign rom_addr    = rom_en ? ADDR_WIDTH'(32'(ch) * IMAGE_SIZE * IMAGE_SIZE
                                 + (32'(row) + 32'(kr)) * IMAGE_SIZE + col) : '0;
    assign mac_en      = (state_q == StMac);
    assign weight_addr = mac_en ? WADDR_WIDTH'((32'(ch) * KERNEL_SIZE + 32'(kr)) * KERNEL_SIZE
                                 + 32'(kc)) : '0;
    assign acc_clr     = mac_en && (kc == '0) && (kr == '0) && (ch == '0);
    assign load_en     = load_en_q;
    assign load_zero   = load_zero_q;
    assign load_idx    = load_idx_q;
    assign out_valid   = (state_q == StEmit);
    assign out_row     = out_valid ? POS_W'(row) : '0;
    assign out_col     = out_valid ? POS_W'(lane_base) : '0;
    assign busy        = state_q inside {StLoad, StMac, StDrain, StEmit};
    assign done        = (state_q == StDone);

    always_comb begin
        out_mask = '0;
        for (int unsigned i = 0; i < ARRAY_SIZE; i++) begin
            out_mask[i] = out_valid && (lane_base + i < OUT_SIZE);
        end
    end

`ifdef CONV_SEQ_PERF_EN
    logic [31:0] perf_cycles_q, perf_stalls_q;

    always_ff @(posedge clk) begin
        if (rst_n || (state_q == StIdle && start)) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            if (busy && !(&perf_cycles_q)) perf_cycles_q <= perf_cycles_q + 32'd1;
            if (out_valid && !out_ready && !(&perf_stalls_q)) perf_stalls_q <= perf_stalls_q + 32'd1;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed self-checking bench: default geometry, partial strip with zero padding, two channels.
module tb_conv_layer_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start, out_ready;
    logic rom_en, load_en, load_zero, mac_en, acc_clr, out_valid, busy, done;
    logic [7:0] rom_addr;
    logic [2:0] load_idx, out_row, out_col;
    logic [5:0] weight_addr, out_mask;

    logic n_start, n_ready;
    logic n_rom_en, n_load_en, n_load_zero, n_mac_en, n_acc_clr, n_out_valid, n_busy, n_done;
    logic [7:0] n_rom_addr;
    logic [2:0] n_load_idx;
    logic [5:0] n_weight_addr;
    logic [3:0] n_out_mask, n_out_row, n_out_col;

    logic c_start, c_ready;
    logic c_rom_en, c_load_en, c_load_zero, c_mac_en, c_acc_clr, c_out_valid, c_busy, c_done;
    logic [7:0] c_rom_addr;
    logic [2:0] c_load_idx, c_out_row, c_out_col;
    logic [5:0] c_weight_addr, c_out_mask;

`ifdef CONV_SEQ_PERF_EN
    logic [31:0] perf_cycles, perf_stalls, n_perf_cycles, n_perf_stalls, c_perf_cycles, c_perf_stalls;
`endif

    conv_layer_sequencer dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rom_en(rom_en), .rom_addr(rom_addr),
        .load_en(load_en), .load_zero(load_zero), .load_idx(load_idx), .weight_addr(weight_addr),
        .mac_en(mac_en), .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready),
        .out_mask(out_mask), .out_row(out_row), .out_col(out_col), .busy(busy), .done(done)
`ifdef CONV_SEQ_PERF_EN
        , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
    );

    conv_layer_sequencer #(.IMAGE_SIZE(9), .ARRAY_SIZE(4)) dut_n (
        .clk(clk), .rst_n(rst_n), .start(n_start), .rom_en(n_rom_en), .rom_addr(n_rom_addr),
        .load_en(n_load_en), .load_zero(n_load_zero), .load_idx(n_load_idx),
        .weight_addr(n_weight_addr), .mac_en(n_mac_en), .acc_clr(n_acc_clr),
        .out_valid(n_out_valid), .out_ready(n_ready), .out_mask(n_out_mask), .out_row(n_out_row),
        .out_col(n_out_col), .busy(n_busy), .done(n_done)
`ifdef CONV_SEQ_PERF_EN
        , .perf_cycles(n_perf_cycles), .perf_stalls(n_perf_stalls)
`endif
    );

    conv_layer_sequencer #(.IN_CHANNELS(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(c_start), .rom_en(c_rom_en), .rom_addr(c_rom_addr),
        .load_en(c_load_en), .load_zero(c_load_zero), .load_idx(c_load_idx),
        .weight_addr(c_weight_addr), .mac_en(c_mac_en), .acc_clr(c_acc_clr),
        .out_valid(c_out_valid), .out_ready(c_ready), .out_mask(c_out_mask), .out_row(c_out_row),
        .out_col(c_out_col), .busy(c_busy), .done(c_done)
`ifdef CONV_SEQ_PERF_EN
        , .perf_cycles(c_perf_cycles), .perf_stalls(c_perf_stalls)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tick_to(input int target);
        while (cyc - t0 < target) tick;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " rom_en"}, 32'(rom_en), 0);
        check({tag, " rom_addr"}, 32'(rom_addr), 0);
        check({tag, " load_en"}, 32'(load_en), 0);
        check({tag, " load_zero"}, 32'(load_zero), 0);
        check({tag, " load_idx"}, 32'(load_idx), 0);
        check({tag, " weight_addr"}, 32'(weight_addr), 0);
        check({tag, " mac_en"}, 32'(mac_en), 0);
        check({tag, " acc_clr"}, 32'(acc_clr), 0);
        check({tag, " out_valid"}, 32'(out_valid), 0);
        check({tag, " out_mask"}, 32'(out_mask), 0);
        check({tag, " out_row"}, 32'(out_row), 0);
        check({tag, " out_col"}, 32'(out_col), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(done), 0);
    endtask

    // First strip of the default layer: per kernel row 8 LOAD cycles then 3 MAC cycles.
    task automatic run_first_strip(input string tag);
        for (int k = 0; k < 33; k++) begin
            int ph = k % 11;
            int kr = k / 11;
            check({tag, " rom_en"}, 32'(rom_en), 32'(ph < 8));
            if (ph < 8) check({tag, " rom_addr"}, 32'(rom_addr), 32'(kr * 8 + ph));
            check({tag, " mac_en"}, 32'(mac_en), 32'(ph >= 8));
            if (ph >= 8) check({tag, " weight_addr"}, 32'(weight_addr), 32'(kr * 3 + ph - 8));
            check({tag, " acc_clr"}, 32'(acc_clr), 32'(k == 8));
            check({tag, " load_en"}, 32'(load_en), 32'(ph >= 1 && ph <= 8));
            if (ph >= 1 && ph <= 8) check({tag, " load_idx"}, 32'(load_idx), 32'(ph - 1));
            check({tag, " load_zero"}, 32'(load_zero), 0);
            check({tag, " busy"}, 32'(busy), 1);
            tick;
        end
        check({tag, " drain mac_en"}, 32'(mac_en), 0);
        check({tag, " drain out_valid"}, 32'(out_valid), 0);
        tick;
        check({tag, " emit cycle"}, 32'(cyc - t0), 34);
        check({tag, " out_valid"}, 32'(out_valid), 1);
        check({tag, " out_row"}, 32'(out_row), 0);
        check({tag, " out_col"}, 32'(out_col), 0);
        check({tag, " out_mask"}, 32'(out_mask), 32'h3f);
    endtask

    initial begin
        int strips;
        int n;
        int clr;
        int wexp;

        rst_n = 1'b1;
        start = 1'b0;
        out_ready = 1'b0;
        n_start = 1'b0;
        n_ready = 1'b1;
        c_start = 1'b0;
        c_ready = 1'b1;
        repeat (3) tick;
        check_quiet("reset");
`ifdef CONV_SEQ_PERF_EN
        check("reset perf_cycles", perf_cycles, 0);
`endif
        rst_n = 1'b0;
        tick;

        // Default layer, first strip, then 10-cycle stall at the first EMIT.
        start = 1'b1;
        tick;
        start = 1'b0;
        t0 = cyc;
        run_first_strip("s1");
        for (int i = 0; i < 10; i++) begin
            check("stall out_valid", 32'(out_valid), 1);
            check("stall out_mask", 32'(out_mask), 32'h3f);
            check("stall out_row", 32'(out_row), 0);
            check("stall rom_en", 32'(rom_en), 0);
            check("stall mac_en", 32'(mac_en), 0);
            tick;
        end
        out_ready = 1'b1;
        check("release out_valid", 32'(out_valid), 1);
        tick;
        check("next load rom_en", 32'(rom_en), 1);
        check("next load rom_addr", 32'(rom_addr), 8);
        check("next load out_valid", 32'(out_valid), 0);
`ifdef CONV_SEQ_PERF_EN
        check("perf_stalls", perf_stalls, 10);
        check("perf_cycles", perf_cycles, 45);
`endif

        // Remaining five strips, with a start pulse mid-run that must be ignored.
        strips = 1;
        n = 0;
        while (!done && n < 400) begin
            if (out_valid) begin
                check("strip out_row", 32'(out_row), 32'(strips));
                check("strip out_mask", 32'(out_mask), 32'h3f);
                strips++;
            end
            start = (n == 20);
            tick;
            n++;
        end
        start = 1'b0;
        check("done seen", 32'(done), 1);
        check("done cycle", 32'(cyc - t0), 220);
        check("strips total", 32'(strips), 6);
        check("done busy", 32'(busy), 0);
        tick;
        check("after done", 32'(done), 0);
        check("after done busy", 32'(busy), 0);

        // Reset in the first MAC cycle, where the last window load lands.
        start = 1'b1;
        tick;
        start = 1'b0;
        t0 = cyc;
        tick_to(8);
        check("pre-reset mac_en", 32'(mac_en), 1);
        check("pre-reset load_en", 32'(load_en), 1);
        rst_n = 1'b1;
        tick;
        check_quiet("mid-mac reset");
`ifdef CONV_SEQ_PERF_EN
        check("mid-mac reset perf_cycles", perf_cycles, 0);
`endif
        rst_n = 1'b0;
        tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        t0 = cyc;
        run_first_strip("s5");

        // 9x9 image, 4 lanes: second strip is partial and pads column 9 with zero.
        n_start = 1'b1;
        tick;
        n_start = 1'b0;
        t0 = cyc;
        tick_to(28);
        check("n strip0 out_valid", 32'(n_out_valid), 1);
        check("n strip0 out_col", 32'(n_out_col), 0);
        check("n strip0 out_mask", 32'(n_out_mask), 32'hf);
        tick_to(33);
        check("n col8 rom_en", 32'(n_rom_en), 1);
        check("n col8 rom_addr", 32'(n_rom_addr), 8);
        tick_to(34);
        check("n col9 rom_en", 32'(n_rom_en), 0);
        check("n col9 load_zero prev", 32'(n_load_zero), 0);
        tick_to(35);
        check("n pad load_en", 32'(n_load_en), 1);
        check("n pad load_zero", 32'(n_load_zero), 1);
        check("n pad load_idx", 32'(n_load_idx), 5);
        check("n strip1 acc_clr", 32'(n_acc_clr), 1);
        tick_to(57);
        check("n strip1 out_valid", 32'(n_out_valid), 1);
        check("n strip1 out_col", 32'(n_out_col), 4);
        check("n strip1 out_row", 32'(n_out_row), 0);
        check("n strip1 out_mask", 32'(n_out_mask), 32'h7);

        // Two input channels: one accumulator clear, second channel at pixel 64, weights 9..17.
        c_start = 1'b1;
        tick;
        c_start = 1'b0;
        t0 = cyc;
        clr = 0;
        wexp = 9;
        for (int k = 0; k < 67; k++) begin
            if (c_acc_clr) clr++;
            if (k == 33) begin
                check("c ch1 rom_en", 32'(c_rom_en), 1);
                check("c ch1 rom_addr", 32'(c_rom_addr), 64);
            end
            if (k >= 33 && c_mac_en) begin
                check("c ch1 weight_addr", 32'(c_weight_addr), 32'(wexp));
                wexp++;
            end
            tick;
        end
        check("c out_valid", 32'(c_out_valid), 1);
        check("c acc_clr count", 32'(clr), 1);
        check("c ch1 weight count", 32'(wexp), 18);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
